lsu_mem_stage: RTL and testbench

- MEM-stage load/store unit of the 5-stage pipeline; sits between the EX/MEM pipeline register and the byte-enabled data memory.
- Accepts one load/store request at a time. Checks alignment and generates the byte enables.
- Drives the memory for one cycle and waits out the memory's 1-cycle registered read latency.
- Lane-extracts and sign/zero-extends load data, then returns a single response pulse to writeback.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_mem_stage_load_align.sv | 28 ++
 rtl/lsu_mem_stage.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM states, byte-enable patterns and request decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, RESP, DONE, ERR} state_t;

    // Illegal funct3 for the direction, or an address not aligned to the access size.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = a[0];
            F3_W:    bad = |a;
            F3_BU:   bad = we;
            F3_HU:   bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by the access; only the size bits of funct3 matter.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'd0:    be = BE_BYTE << a;
            2'd1:    be = a[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load data lane extraction: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;

    // Lane shift followed by width-dependent extension.
    always_comb begin
        shifted = word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: accepts one request at a time, drives the
// byte-enabled data memory for one cycle, waits out its read latency and
// returns a single response pulse.
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  perf_ld_cnt,
    output logic [CNT_WIDTH-1:0]  perf_st_cnt,
    output logic [CNT_WIDTH-1:0]  perf_err_cnt
`endif
);

    state_t                state_reg, state_next;
    logic                  we_reg;
    logic [2:0]            f3_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [3:0]            be_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] align_data;

    // CNT_WIDTH only sizes the optional counters; referenced here so every build elaborates it.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word    (mem_rdata),
        .addr_lo (addr_reg[1:0]),
        .funct3  (f3_reg),
        .data    (align_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Request capture at accept and load result capture in CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg    <= 1'b0;
            f3_reg    <= 3'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= 4'd0;
            rdata_reg <= '0;
        end else begin
            if (req_valid && req_ready) begin
                we_reg    <= req_we;
                f3_reg    <= req_funct3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                be_reg    <= byte_en(req_funct3, req_addr[1:0]);
            end
            if (state_reg == CAPTURE) rdata_reg <= align_data;
        end
    end

    // Next-state and output decode; memory signals are live only in ACCESS.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = 4'd0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_bad(req_we, req_funct3, req_addr[1:0]) ? ERR : ACCESS;
            end
            ACCESS: begin
                mem_rd     = !we_reg;
                mem_wr     = we_reg;
                mem_addr   = addr_reg;
                mem_wdata  = wdata_reg;
                mem_be     = be_reg;
                state_next = we_reg ? DONE : CAPTURE;
            end
            CAPTURE: state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_reg;
                state_next = IDLE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef LSU_PERF_CNT_EN
    // Saturating completion counters, one per response kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ld_cnt  <= '0;
            perf_st_cnt  <= '0;
            perf_err_cnt <= '0;
        end else begin
            if (state_reg == RESP && !(&perf_ld_cnt))  perf_ld_cnt  <= perf_ld_cnt + 1'b1;
            if (state_reg == DONE && !(&perf_st_cnt))  perf_st_cnt  <= perf_st_cnt + 1'b1;
            if (state_reg == ERR  && !(&perf_err_cnt)) perf_err_cnt <= perf_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases followed by random
// loads/stores checked against a byte-addressed reference memory.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata)
    );

    // Word memory with registered read; it places unshifted write data into the addressed lanes.
    logic [31:0] tb_mem [0:63];
    logic [31:0] mem_wdata_sh;
    assign mem_wdata_sh = mem_wdata << {mem_addr[1:0], 3'b000};

    always @(posedge clk) begin
        if (mem_wr)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) tb_mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata_sh[8*i +: 8];
        if (mem_rd) mem_rdata <= tb_mem[mem_addr[7:2]];
    end

    // Reference model: plain byte array, little-endian, 256-byte alias window.
    logic [7:0] ref_mem [0:255];

    function automatic int ref_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit ref_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (int'(a[1:0]) % ref_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        m = (32'd1 << ref_size(f3)) - 32'd1;
        m = m << a[1:0];
        return m;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        logic [7:0]  idx;
        int          n;
        v = 32'd0;
        n = ref_size(f3);
        for (int i = 0; i < n; i++) begin
            idx = a[7:0] + 8'(i);
            v[8*i +: 8] = ref_mem[idx];
        end
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] idx;
        for (int i = 0; i < ref_size(f3); i++) begin
            idx = a[7:0] + 8'(i);
            ref_mem[idx] = d[8*i +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request/response, checked cycle by cycle from accept onwards.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit          bad;
        logic [31:0] exp;
        logic [31:0] r;
        bad = ref_bad(we, f3, a);
        exp = 32'd0;
        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        // Scramble the request bus: the unit must work from its captured copy.
        req_valid = 1'b0;
        r = $urandom(); req_addr = r;
        r = $urandom(); req_wdata = r;
        r = $urandom(); req_funct3 = r[2:0]; req_we = r[3];
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        if (bad) begin
            chk("err_valid", {31'd0, resp_valid}, 32'd1);
            chk("err_flag", {31'd0, resp_err}, 32'd1);
            chk("err_rdata", resp_rdata, 32'd0);
            chk("err_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        end else begin
            chk("acc_rd", {31'd0, mem_rd}, {31'd0, !we});
            chk("acc_wr", {31'd0, mem_wr}, {31'd0, we});
            chk("acc_addr", mem_addr, a);
            chk("acc_be", {28'd0, mem_be}, ref_be(f3, a));
            chk("acc_wdata", mem_wdata, wd);
            chk("acc_noresp", {31'd0, resp_valid}, 32'd0);
            if (we) begin
                ref_store(f3, a, wd);
                @(negedge clk);
                chk("st_valid", {31'd0, resp_valid}, 32'd1);
                chk("st_err", {31'd0, resp_err}, 32'd0);
                chk("st_rdata", resp_rdata, 32'd0);
                chk("st_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
            end else begin
                exp = ref_load(f3, a);
                @(negedge clk);
                chk("cap_noresp", {31'd0, resp_valid}, 32'd0);
                chk("cap_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
                @(negedge clk);
                chk("ld_valid", {31'd0, resp_valid}, 32'd1);
                chk("ld_err", {31'd0, resp_err}, 32'd0);
                chk("ld_rdata", resp_rdata, exp);
            end
        end
        $display("txn %s f3=%0d addr=%h wdata=%h err=%0b rdata=%h",
                 we ? "ST" : "LD", f3, a, wd, bad, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] exp;

        for (int i = 0; i < 64; i++)  tb_mem[i] = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        mem_rdata = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp", {29'd0, resp_valid, resp_err, 1'b0}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem", {26'd0, mem_rd, mem_wr, mem_be}, 32'd0);
        chk("rst_maddr", mem_addr | mem_wdata, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        run_req(1'b0, 3'd2, 32'h10, 32'h0);
        run_req(1'b1, 3'd0, 32'h21, 32'h0000_0080);
        run_req(1'b0, 3'd0, 32'h21, 32'h0);
        run_req(1'b0, 3'd4, 32'h21, 32'h0);
        run_req(1'b1, 3'd1, 32'h32, 32'h0000_8001);
        run_req(1'b0, 3'd1, 32'h32, 32'h0);
        run_req(1'b0, 3'd5, 32'h32, 32'h0);
        run_req(1'b0, 3'd2, 32'h13, 32'h0);
        run_req(1'b1, 3'd1, 32'h05, 32'h1234_5678);
        run_req(1'b0, 3'd3, 32'h40, 32'h0);
        run_req(1'b1, 3'd4, 32'h40, 32'h0);
        chk("tp_lw", ref_load(3'd2, 32'h10), 32'hDEAD_BEEF);
        chk("tp_lb", ref_load(3'd0, 32'h21), 32'hFFFF_FF80);

        // Reset asserted while a load sits in CAPTURE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("abort_resp2", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_resp3", {31'd0, resp_valid}, 32'd0);
        chk("abort_idle", {31'd0, req_ready}, 32'd1);
        $display("txn ABORT load at 00000010 reset during capture");

        // Back-to-back loads with req_valid held high.
        exp = ref_load(3'd2, 32'h10);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        for (int k = 0; k < 16; k++) begin
            chk("b2b_ready", {31'd0, req_ready}, {31'd0, (k % 4) == 0});
            chk("b2b_resp", {31'd0, resp_valid}, {31'd0, (k % 4) == 3});
            chk("b2b_rd", {31'd0, mem_rd}, {31'd0, (k % 4) == 1});
            if ((k % 4) == 3) chk("b2b_rdata", resp_rdata, exp);
            @(negedge clk);
        end
        req_valid = 1'b0;
        $display("txn B2B four loads at 00000010 rdata=%h", exp);

        // Random traffic; low address bits often forced aligned.
        for (int n = 0; n < 80; n++) begin
            r = $urandom();
            a = $urandom();
            if (r[5:4] != 2'd0) a[1:0] = 2'd0;
            run_req(r[0], r[3:1], a, $urandom());
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
